fir_out_writer: RTL and testbench



---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_round_sat.sv | 38 +++
 rtl/fir_out_writer.sv | 127 ++++++++++++
 tb/tb_fir_out_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output writer: default widths, frame geometry,
// state encoding and a saturating counter helper.
package fir_pkg;

    localparam int IN_W_DEF  = 22;
    localparam int OUT_W_DEF = 12;
    localparam int SHIFT_DEF = 10;
    localparam int FILL_DEF  = 6;
    localparam int FRAME_LEN = 256;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational quantiser: round-half-up right shift, then clamp to the signed
// OUT_W range. clip_o flags samples that needed clamping.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic [IN_W-1:0]  x_i,
    output logic [OUT_W-1:0] q_o,
    output logic             clip_o
);

    localparam logic [IN_W:0]        HALF  = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(-(2**(OUT_W-1)));

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;

    // One extra bit so the rounding offset can never overflow the sum
    assign sum     = $signed({x_i[IN_W-1], x_i} + HALF);
    assign shifted = sum >>> SHIFT;

    always_comb begin
        q_o    = shifted[OUT_W-1:0];
        clip_o = 1'b0;
        if (shifted > MAX_V) begin
            q_o    = MAX_V[OUT_W-1:0];
            clip_o = 1'b1;
        end else if (shifted < MIN_V) begin
            q_o    = MIN_V[OUT_W-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/fir_out_writer.sv
// Writes one 256-sample frame of quantised FIR output into the result memory,
// skipping the filter fill cycles after start.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FILL  | counting down filter pipeline fill cycles
//   ST_WRITE | one memory write per cycle, addresses 0..255
//   ST_DONE  | release memory strobes, pulse done
module fir_out_writer
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int FILL  = FILL_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic [IN_W-1:0]   din,
    output logic              NWRT,
    output logic              NCE,
    output logic [7:0]        ADDR,
    output logic [OUT_W-1:0]  DO,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sat_cnt
);

    state_e             state_q;
    logic [7:0]         fill_cnt_q;
    logic [7:0]         wr_cnt_q;
    logic               nwrt_q;
    logic               nce_q;
    logic [7:0]         addr_q;
    logic [OUT_W-1:0]   do_q;
    logic               busy_q;
    logic               done_q;
    logic [7:0]         sat_cnt_q;

    logic [OUT_W-1:0]   q_d;
    logic               clip_d;

    fir_round_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .x_i    (din),
        .q_o    (q_d),
        .clip_o (clip_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            wr_cnt_q   <= '0;
            nwrt_q     <= 1'b1;
            nce_q      <= 1'b1;
            addr_q     <= '0;
            do_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
                nwrt_q  <= 1'b1;
                nce_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q    <= ST_FILL;
                            fill_cnt_q <= 8'(FILL - 1);
                            sat_cnt_q  <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_FILL: begin
                        if (fill_cnt_q == 8'd0) begin
                            state_q  <= ST_WRITE;
                            wr_cnt_q <= '0;
                        end else begin
                            fill_cnt_q <= fill_cnt_q - 8'd1;
                        end
                    end
                    ST_WRITE: begin
                        do_q     <= q_d;
                        addr_q   <= wr_cnt_q;
                        nwrt_q   <= 1'b0;
                        nce_q    <= 1'b0;
                        wr_cnt_q <= wr_cnt_q + 8'd1;
                        if (clip_d) begin
                            sat_cnt_q <= sat_inc8(sat_cnt_q);
                        end
                        // Address 255 is the last write of the frame
                        if (wr_cnt_q == 8'(FRAME_LEN - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        nwrt_q  <= 1'b1;
                        nce_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign NWRT    = nwrt_q;
    assign NCE     = nce_q;
    assign ADDR    = addr_q;
    assign DO      = do_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_writer.sv
// Randomised frame-level bench for fir_out_writer against an arithmetic
// reference model of quantisation, write timing and saturation counting.
module tb_fir_out_writer;

    localparam int FILL_C  = 6;
    localparam int SHIFT_C = 10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        stop;
    logic [21:0] din;
    logic        NWRT;
    logic        NCE;
    logic [7:0]  ADDR;
    logic [11:0] DO;
    logic        busy;
    logic        done;
    logic [7:0]  sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_addr = '0;
    logic [11:0] exp_do   = '0;
    int          exp_sat  = 0;

    logic [21:0] dir_din [7];
    logic [11:0] dir_exp [7];

    fir_out_writer #(
        .IN_W  (22),
        .OUT_W (12),
        .SHIFT (SHIFT_C),
        .FILL  (FILL_C)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .stop    (stop),
        .din     (din),
        .NWRT    (NWRT),
        .NCE     (NCE),
        .ADDR    (ADDR),
        .DO      (DO),
        .busy    (busy),
        .done    (done),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Floor-division rounding of (x + half) / 2^SHIFT, then clamp to 12 bits
    function automatic int q_ref(input logic [21:0] d, output bit clipped);
        longint x, v, f, div;
        div = longint'(1) << SHIFT_C;
        x   = longint'($signed(d));
        v   = x + (div / 2);
        if (v >= 0) f = v / div;
        else        f = -((-v + div - 1) / div);
        clipped = 1'b0;
        if (f > 2047) begin
            f = 2047;
            clipped = 1'b1;
        end else if (f < -2048) begin
            f = -2048;
            clipped = 1'b1;
        end
        return int'(f);
    endfunction

    function automatic logic [21:0] clip_val();
        return 22'($urandom_range(2096640, 2097151));
    endfunction

    function automatic logic [21:0] calm_val();
        return 22'(int'($urandom_range(0, 2**21 - 1)) - 2**20);
    endfunction

    // mode 0: random, 1: three clipped writes (fill samples also clipped),
    // 2: every sample clipped, 3: directed rounding values then ramp
    task automatic run_frame(input int mode, input int stop_k, input bit repulse);
        logic [21:0] hist [0:299];
        int  pos0, pos1, pos2;
        int  abort_m, total, m, k, qv;
        bit  c, wr;
        pos0    = $urandom_range(0, 84);
        pos1    = $urandom_range(85, 169);
        pos2    = $urandom_range(170, 255);
        abort_m = (stop_k >= 0) ? FILL_C + 2 + stop_k : 100000;
        total   = (stop_k >= 0) ? abort_m + 5 : FILL_C + 262;
        for (int n = 0; n <= total; n++) begin
            @(negedge clk);
            if (n > 0) begin
                m  = n - 1;
                k  = m - FILL_C - 1;
                wr = (m < abort_m) && (k >= 0) && (k <= 255);
                if (m == 0 && m < abort_m) exp_sat = 0;
                if (wr) begin
                    qv       = q_ref(hist[m], c);
                    exp_addr = 8'(k);
                    exp_do   = 12'(qv);
                    if (c && exp_sat < 255) exp_sat++;
                end
                chk("nwrt", NWRT, !wr);
                chk("nce", NCE, !wr);
                chk("addr", ADDR, exp_addr);
                chk("do", DO, exp_do);
                chk("busy", busy, (m < abort_m) && (m <= FILL_C + 255));
                chk("done", done, (m < abort_m) && (m == FILL_C + 257));
                chk("sat_cnt", sat_cnt, exp_sat);
                if (mode == 3 && wr && k < 7) chk("round_directed", DO, dir_exp[k]);
            end
            start = (n == 0) || (repulse && (n == 3 || n == FILL_C + 50));
            stop  = (n == abort_m);
            k     = n - FILL_C - 1;
            case (mode)
                1: din = (k < 0 || k == pos0 || k == pos1 || k == pos2) ? clip_val() : calm_val();
                2: din = clip_val();
                3: din = (k >= 0 && k < 7) ? dir_din[k] : 22'(n);
                default: din = 22'($urandom);
            endcase
            hist[n] = din;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic reset_mid(input int at_n);
        for (int n = 0; n <= at_n; n++) begin
            @(negedge clk);
            start = (n == 0);
            din   = 22'($urandom);
        end
        start = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_nwrt", NWRT, 1);
        chk("rst_nce", NCE, 1);
        chk("rst_addr", ADDR, 0);
        chk("rst_do", DO, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat_cnt, 0);
        exp_addr = '0;
        exp_do   = '0;
        exp_sat  = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_nwrt", NWRT, 1);
            chk("rst_hold_busy", busy, 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_nwrt", NWRT, 1);
        chk("post_rst_busy", busy, 0);
    endtask

    task automatic start_stop_idle();
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < FILL_C + 4; i++) begin
            chk("ss_busy", busy, 0);
            chk("ss_nwrt", NWRT, 1);
            chk("ss_done", done, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        dir_din[0] = 22'h000400; dir_exp[0] = 12'h001;
        dir_din[1] = 22'h000200; dir_exp[1] = 12'h001;
        dir_din[2] = 22'h0001FF; dir_exp[2] = 12'h000;
        dir_din[3] = 22'h3FFE00; dir_exp[3] = 12'h000;
        dir_din[4] = 22'h3FFDFF; dir_exp[4] = 12'hFFF;
        dir_din[5] = 22'h1FFFFF; dir_exp[5] = 12'h7FF;
        dir_din[6] = 22'h200000; dir_exp[6] = 12'h800;

        rstn  = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        din   = '0;
        #2 rstn = 1'b0;
        #1;
        chk("init_nwrt", NWRT, 1);
        chk("init_nce", NCE, 1);
        chk("init_addr", ADDR, 0);
        chk("init_do", DO, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_sat", sat_cnt, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        run_frame(3, -1, 1'b0);
        run_frame(1, -1, 1'b1);
        chk("sat_three", sat_cnt, 3);
        run_frame(2, -1, 1'b0);
        chk("sat_all", sat_cnt, 255);
        run_frame(0, -1, 1'b0);
        run_frame(0, 100, 1'b0);
        chk("stop_addr", ADDR, 100);
        run_frame(0, -1, 1'b0);
        start_stop_idle();
        reset_mid(3);
        run_frame(1, -1, 1'b0);
        reset_mid(FILL_C + 50);
        run_frame(0, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
